// File: rtl/low_freq_pkg.sv
// Shared types and constants for the low-frequency meter.
package low_freq_pkg;

  // Top-level sequencing: measure, divide, convert, publish.
  typedef enum logic [2:0] {T_IDLE, T_COUNT, T_FRQ, T_B2B, T_DONE} top_state_t;

  // Period measurement: wait for first rising edge, then count until the next one.
  typedef enum logic [1:0] {P_IDLE, P_WAITE, P_COUNT, P_DONE} prd_state_t;

  // Sequential restoring divider.
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_t;

  // Double-dabble binary to BCD conversion.
  typedef enum logic [1:0] {B_IDLE, B_RUN, B_DONE} bcd_state_t;

  // Microseconds per second: frequency in Hz = DVND / period_us.
  localparam int DVND    = 1000000;
  // Largest value shown on four decimal digits; larger results clamp here.
  localparam int BCD_MAX = 9999;
  // Binary width fed to the BCD converter (enough for 9999).
  localparam int BIN_W   = 14;

  // Double-dabble correction: a digit of 5 or more would overflow a decimal
  // place after the next shift, so pre-add 3.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/low_freq_div.sv
// PW-bit restoring divider: one quotient bit per cycle, PW cycles of work
// followed by a single-cycle done strobe. The quotient holds until the next start.
module low_freq_div #(
  parameter int PW = 20
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          start,
  input  logic [PW-1:0] dividend,
  input  logic [PW-1:0] divisor,
  output logic [PW-1:0] quo,
  output logic          done
);
  import low_freq_pkg::*;

  localparam int CW = $clog2(PW + 1);

  div_state_t    state_reg, state_next;
  logic [PW:0]   rem_reg;
  logic [PW-1:0] dvd_reg;
  logic [PW-1:0] dvs_reg;
  logic [PW-1:0] quo_reg;
  logic [CW-1:0] cnt_reg;

  logic [PW:0]   rem_shift;
  logic [PW:0]   rem_sub;
  logic          q_bit;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_reg[PW-1:0], dvd_reg[PW-1]};
    rem_sub   = rem_shift - {1'b0, dvs_reg};
    q_bit     = (rem_shift >= {1'b0, dvs_reg});
  end

  // Next-state logic: PW iterations, then one done cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      D_IDLE:  if (start) state_next = D_RUN;
      D_RUN:   if (cnt_reg == CW'(PW - 1)) state_next = D_DONE;
      D_DONE:  state_next = D_IDLE;
      default: state_next = D_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (srst) state_reg <= D_IDLE;
    else      state_reg <= state_next;
  end

  // Datapath: load operands on start, shift/subtract while running.
  always_ff @(posedge clk) begin
    if (srst) begin
      rem_reg <= '0;
      dvd_reg <= '0;
      dvs_reg <= '0;
      quo_reg <= '0;
      cnt_reg <= '0;
    end else if (state_reg == D_IDLE && start) begin
      rem_reg <= '0;
      dvd_reg <= dividend;
      dvs_reg <= divisor;
      quo_reg <= '0;
      cnt_reg <= '0;
    end else if (state_reg == D_RUN) begin
      rem_reg <= q_bit ? rem_sub : rem_shift;
      dvd_reg <= {dvd_reg[PW-2:0], 1'b0};
      quo_reg <= {quo_reg[PW-2:0], q_bit};
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign quo  = quo_reg;
  assign done = (state_reg == D_DONE);

endmodule

// File: rtl/low_freq_counter.sv
// Low-frequency meter: measures one period of si in microseconds, divides
// 1e6 by it, converts the clamped result to four BCD digits and holds them.
module low_freq_counter #(
  parameter int CLK_US_COUNT = 50,
  parameter int PW           = 20,
  parameter int DVND         = low_freq_pkg::DVND
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       start_amisha,
  input  logic       si_amisha,
  output logic [3:0] bcd3_amisha,
  output logic [3:0] bcd2_amisha,
  output logic [3:0] bcd1_amisha,
  output logic [3:0] bcd0_amisha
);
  import low_freq_pkg::*;

  localparam int TW = (CLK_US_COUNT > 1) ? $clog2(CLK_US_COUNT) : 1;

  logic clk;
  logic srst;
  assign clk  = clk_amisha;
  assign srst = reset_amisha;

  // ---------------- input conditioning ----------------
  logic sync1_reg, sync2_reg, dly_reg;
  logic rise;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      dly_reg   <= 1'b0;
    end else begin
      sync1_reg <= si_amisha;
      sync2_reg <= sync1_reg;
      dly_reg   <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~dly_reg;

  // ---------------- top sequencer ----------------
  top_state_t top_reg, top_next;
  logic       prd_start, div_start, bcd_start;
  logic       prd_done, div_done, bcd_done;

  // Top next-state and one-cycle start strobes for each stage.
  always_comb begin
    top_next  = top_reg;
    prd_start = 1'b0;
    div_start = 1'b0;
    bcd_start = 1'b0;
    case (top_reg)
      T_IDLE:  if (start_amisha) begin top_next = T_COUNT; prd_start = 1'b1; end
      T_COUNT: if (prd_done)     begin top_next = T_FRQ;   div_start = 1'b1; end
      T_FRQ:   if (div_done)     begin top_next = T_B2B;   bcd_start = 1'b1; end
      T_B2B:   if (bcd_done)     top_next = T_DONE;
      T_DONE:  top_next = T_IDLE;
      default: top_next = T_IDLE;
    endcase
  end

  // Top state register.
  always_ff @(posedge clk) begin
    if (srst) top_reg <= T_IDLE;
    else      top_reg <= top_next;
  end

  // ---------------- period counter ----------------
  prd_state_t    prd_reg, prd_next;
  logic [TW-1:0] t_reg;
  logic [PW-1:0] p_reg;
  logic          us_tick;

  assign us_tick  = (t_reg == TW'(CLK_US_COUNT - 1));
  assign prd_done = (prd_reg == P_DONE);

  // Period next-state: no timeout, a missing edge leaves the FSM waiting.
  always_comb begin
    prd_next = prd_reg;
    case (prd_reg)
      P_IDLE:  if (prd_start) prd_next = P_WAITE;
      P_WAITE: if (rise)      prd_next = P_COUNT;
      P_COUNT: if (rise)      prd_next = P_DONE;
      P_DONE:  prd_next = P_IDLE;
      default: prd_next = P_IDLE;
    endcase
  end

  // Period state register.
  always_ff @(posedge clk) begin
    if (srst) prd_reg <= P_IDLE;
    else      prd_reg <= prd_next;
  end

  // Microsecond prescaler and saturating period count; the cycle of the
  // closing edge is counted so p equals the full edge-to-edge interval.
  always_ff @(posedge clk) begin
    if (srst) begin
      t_reg <= '0;
      p_reg <= '0;
    end else if (prd_reg == P_WAITE) begin
      t_reg <= '0;
      p_reg <= '0;
    end else if (prd_reg == P_COUNT) begin
      if (us_tick) begin
        t_reg <= '0;
        if (p_reg != {PW{1'b1}}) p_reg <= p_reg + PW'(1);
      end else begin
        t_reg <= t_reg + TW'(1);
      end
    end
  end

  // ---------------- divider ----------------
  logic [PW-1:0] quo;

  low_freq_div #(.PW(PW)) u_div (
    .clk      (clk),
    .srst     (srst),
    .start    (div_start),
    .dividend (PW'(DVND)),
    .divisor  (p_reg),
    .quo      (quo),
    .done     (div_done)
  );

  // Clamp to the display range; a zero period also shows as full scale.
  logic [BIN_W-1:0] bin_sat;

  // Saturation of the quotient before conversion.
  always_comb begin
    if (p_reg == '0 || quo > PW'(BCD_MAX)) bin_sat = BIN_W'(BCD_MAX);
    else                                  bin_sat = quo[BIN_W-1:0];
  end

  // ---------------- binary to BCD ----------------
  bcd_state_t       bcd_reg, bcd_next;
  logic [BIN_W-1:0] bin_reg;
  logic [15:0]      dig_reg;
  logic [15:0]      dig_adj;
  logic [3:0]       bcnt_reg;

  assign bcd_done = (bcd_reg == B_DONE);

  for (genvar gi = 0; gi < 4; gi++) begin : g_add3
    assign dig_adj[gi*4 +: 4] = add3(dig_reg[gi*4 +: 4]);
  end

  // BCD next-state: BIN_W shifts, then one done cycle.
  always_comb begin
    bcd_next = bcd_reg;
    case (bcd_reg)
      B_IDLE:  if (bcd_start) bcd_next = B_RUN;
      B_RUN:   if (bcnt_reg == 4'(BIN_W - 1)) bcd_next = B_DONE;
      B_DONE:  bcd_next = B_IDLE;
      default: bcd_next = B_IDLE;
    endcase
  end

  // BCD state register.
  always_ff @(posedge clk) begin
    if (srst) bcd_reg <= B_IDLE;
    else      bcd_reg <= bcd_next;
  end

  // Double-dabble datapath: adjust every digit, then shift one binary bit in.
  always_ff @(posedge clk) begin
    if (srst) begin
      bin_reg  <= '0;
      dig_reg  <= '0;
      bcnt_reg <= '0;
    end else if (bcd_reg == B_IDLE && bcd_start) begin
      bin_reg  <= bin_sat;
      dig_reg  <= '0;
      bcnt_reg <= '0;
    end else if (bcd_reg == B_RUN) begin
      dig_reg  <= {dig_adj[14:0], bin_reg[BIN_W-1]};
      bin_reg  <= {bin_reg[BIN_W-2:0], 1'b0};
      bcnt_reg <= bcnt_reg + 4'd1;
    end
  end

  // ---------------- display hold ----------------
  logic [15:0] out_reg;

  // Publish the converted digits only when the sequence completes.
  always_ff @(posedge clk) begin
    if (srst)                  out_reg <= '0;
    else if (top_reg == T_DONE) out_reg <= dig_reg;
  end

  assign bcd3_amisha = out_reg[15:12];
  assign bcd2_amisha = out_reg[11:8];
  assign bcd1_amisha = out_reg[7:4];
  assign bcd0_amisha = out_reg[3:0];

endmodule

// File: tb/tb_low_freq_counter.sv
// Bench for low_freq_counter with a 1-cycle microsecond tick and 50 ns clock.
module tb_low_freq_counter;

  logic       clk = 1'b0;
  logic       srst;
  logic       start;
  logic       si;
  logic [3:0] b3, b2, b1, b0;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_exp = 16'h0000;

  always #25 clk = ~clk;

  low_freq_counter #(.CLK_US_COUNT(1), .PW(20)) dut (
    .clk_amisha   (clk),
    .reset_amisha (srst),
    .start_amisha (start),
    .si_amisha    (si),
    .bcd3_amisha  (b3),
    .bcd2_amisha  (b2),
    .bcd1_amisha  (b1),
    .bcd0_amisha  (b0)
  );

  // Reference: frequency in Hz from a period in microseconds, clamped, as digits.
  function automatic logic [15:0] ref_bcd(input int period_us);
    int f;
    if (period_us == 0) f = 9999;
    else                f = 1000000 / period_us;
    if (f > 9999) f = 9999;
    return {4'(f / 1000), 4'((f / 100) % 10), 4'((f / 10) % 10), 4'(f % 10)};
  endfunction

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full measurement: start, two rising edges one period apart, then wait
  // well past the pipeline latency. Optional extra start during counting and
  // optional reset shortly after the second edge (while dividing).
  task automatic measure(input string tag, input int period, input bit extra_start,
                         input bit reset_mid);
    int hi, lo;
    hi = period / 2;
    if (hi < 1) hi = 1;
    lo = period - hi;
    si = 1'b0;
    cyc(4);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    si = 1'b1;
    cyc(hi);
    si = 1'b0;
    if (extra_start && lo > 4) begin
      cyc(lo / 2);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(lo - lo / 2 - 1);
    end else begin
      cyc(lo);
    end
    si = 1'b1;
    if (reset_mid) begin
      cyc(8);
      srst = 1'b1;
      cyc(1);
      srst = 1'b0;
      last_exp = 16'h0000;
      check_val({tag, "_reset"}, {b3, b2, b1, b0}, last_exp);
      si = 1'b0;
      cyc(60);
      check_val({tag, "_idle"}, {b3, b2, b1, b0}, last_exp);
      $display("txn %s period=%0d reset mid-divide out=%h", tag, period, {b3, b2, b1, b0});
      return;
    end
    cyc(10);
    check_val({tag, "_early"}, {b3, b2, b1, b0}, last_exp);
    si = 1'b0;
    cyc(80);
    last_exp = ref_bcd(period);
    check_val(tag, {b3, b2, b1, b0}, last_exp);
    $display("txn %s period=%0d out=%h exp=%h", tag, period, {b3, b2, b1, b0}, last_exp);
  endtask

  initial begin
    int per;
    srst  = 1'b1;
    start = 1'b0;
    si    = 1'b0;
    cyc(2);
    srst = 1'b0;
    check_val("reset", {b3, b2, b1, b0}, 16'h0000);

    // Input toggles without start: display must stay cleared.
    for (int i = 0; i < 4; i++) begin
      si = 1'b1;
      cyc(50);
      si = 1'b0;
      cyc(50);
    end
    check_val("no_start", {b3, b2, b1, b0}, 16'h0000);

    measure("p1000", 1000, 1'b0, 1'b0);
    measure("p400", 400, 1'b0, 1'b0);
    measure("p3", 3, 1'b0, 1'b0);
    measure("p1000_restart", 1000, 1'b1, 1'b0);
    measure("rst_frq", 1000, 1'b0, 1'b1);
    measure("after_rst", 1000, 1'b0, 1'b0);
    measure("p100", 100, 1'b0, 1'b0);
    measure("p101", 101, 1'b0, 1'b0);
    measure("p7", 7, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      per = $urandom_range(60, 2500);
      measure($sformatf("rnd%0d", k), per, 1'b0, 1'b0);
    end

    // si already high at start: no rising edge, so nothing is published.
    si = 1'b1;
    cyc(4);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(500);
    check_val("hold_high", {b3, b2, b1, b0}, last_exp);
    $display("txn hold_high out=%h exp=%h", {b3, b2, b1, b0}, last_exp);

    // The pending measurement completes once edges arrive.
    si = 1'b0;
    cyc(3);
    si = 1'b1;
    cyc(500);
    si = 1'b0;
    cyc(500);
    si = 1'b1;
    cyc(10);
    si = 1'b0;
    cyc(80);
    last_exp = ref_bcd(1000);
    check_val("resume", {b3, b2, b1, b0}, last_exp);
    $display("txn resume period=1000 out=%h exp=%h", {b3, b2, b1, b0}, last_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
